sarray_storec_drain: RTL and testbench
======================================

// Module: sarray_storec_drain
// PURPOSE
// Drains the accumulated C tile out of the systolic array after a TMMA sequence and writes it to memory.
// Sits downstream of the sarray bottom edge and drives the sarray write channel (aw valid/ready/addr/data).
// sarray has no backpressure, so rows are pulled one at a time with credits and staged in a small FIFO.
// Raises a one-cycle done pulse, which the tinst issue logic uses to retire the STOREC instruction.
// PARAMETERS
// ADDR_WIDTH     64   memory address width
// STORE_WIDTH    256  bits per C row (matches SARRAY_STORE_WIDTH)
// CNT_WIDTH      6    row index width (matches TMMA_CNT_WIDTH)
// ROWS           64   rows per C tile, equal to 2**CNT_WIDTH
// FIFO_DEPTH     4    staging FIFO entries; power of two, >=2
// ROW_SHIFT      8    row stride in memory = 1<<ROW_SHIFT bytes
// PORTS
// clk                 in   1            clock
// rst_n               in   1            reset, asynchronous, active-low
// storec_valid_i      in   1            STOREC request from issue
// storec_ready_o      out  1            accepts request; high only in IDLE
// storec_addr_i       in   ADDR_WIDTH   C tile base address
// post_storec_valid_o out  1            one-cycle pull: sarray emits exactly one row per pulse
// bot_valid_i         in   1            row valid from sarray bottom edge
// bot_cnt_i           in   CNT_WIDTH    row index of bot_data_i
// bot_data_i          in   STORE_WIDTH  row data
// aw_valid_o          out  1            write request valid
// aw_ready_i          in   1            write request accepted
// aw_addr_o           out  ADDR_WIDTH   base + (row << ROW_SHIFT)
// aw_data_o           out  STORE_WIDTH  row data
// storec_done_o       out  1            one-cycle pulse after the last row's aw handshake
// err_o               out  1            sticky: unsolicited bot_valid_i or FIFO overflow; cleared only by reset
// BEHAVIOUR
// - Reset values: every output is 0. The FSM is in IDLE. All counters, credits and FIFO pointers are 0.
// - States and transitions:
//   IDLE:  storec_ready_o=1. A handshake latches base_r and clears req_cnt/wr_cnt, then goes to DRAIN.
//   DRAIN: requests rows, stages them and writes them out. When wr_cnt==ROWS-1 and an aw handshake occurs, go to DONE.
//   DONE:  storec_done_o=1 for this cycle only, then go to IDLE.
// - Credits: outstanding = pulses issued minus rows received.
//   post_storec_valid_o=1 in DRAIN when req_cnt<ROWS and fifo_count + outstanding < FIFO_DEPTH.
//   This guarantees the FIFO never overflows for any sarray latency >=1.
// - Row counting: each pulse increments req_cnt. Each accepted bot_valid_i pushes {bot_cnt_i, bot_data_i} and decrements outstanding.
// - A pulse and a row arrival in the same cycle leave outstanding unchanged. A push and a pop in the same cycle leave fifo_count unchanged.
// - Address: aw_addr_o = base_r + ({ADDR_WIDTH'(cnt)} << ROW_SHIFT), computed at ADDR_WIDTH width with wrap and no overflow flag.
// - aw_valid_o = FIFO not empty, and aw_data_o/aw_addr_o come from the FIFO head.
// - Latency: a row arriving at cycle t into an empty FIFO gives aw_valid_o=1 at t+1.
// - AW handshake: aw_valid_o and the payload hold stable until aw_ready_i; a handshake pops the head and increments wr_cnt.
// - err_o is set when bot_valid_i arrives with outstanding==0 (including in IDLE/DONE). The row is dropped and no push occurs.
// - req_cnt and wr_cnt are CNT_WIDTH+1 wide so the value ROWS is representable with no wrap.
// - Reset mid-operation: all state is discarded immediately. Any row sarray emits afterwards is unsolicited and sets err_o; the issue side must reset sarray together with this block.
// - storec_valid_i is ignored outside IDLE, and no request is queued.
// STRUCTURE
// - Shared package/defines: ADDR_WIDTH, SARRAY_STORE_WIDTH, TMMA_CNT_WIDTH, and the state encoding localparams IDLE=2'd0, DRAIN=2'd1, DONE=2'd2.
// - One sub-module, sync_fifo (WIDTH=CNT_WIDTH+STORE_WIDTH, DEPTH=FIFO_DEPTH), exposing count, full and empty flags.
//   It is reusable for the load-side staging.
// - The top level holds the FSM, req/wr counters, credit counter, address adder and error flag.
// TESTING
// - Basic drain: base=0x1000, sarray model latency 1, aw_ready_i=1.
//   Expect 64 aw writes at 0x1000, 0x1100 .. 0x4F00 with data == row pattern, then storec_done_o high exactly one cycle after the last handshake.
// - Backpressure: aw_ready_i low for 20 cycles mid-tile.
//   Expect at most FIFO_DEPTH rows outstanding+queued, no pulses while saturated, payload stable during stall, err_o=0, and all 64 rows written in order.
// - Long latency: sarray latency 7 with random aw_ready_i.
//   Expect fifo_count+outstanding never exceeds 4, data integrity on all rows, and exactly 64 pulses.
// - Unsolicited row: bot_valid_i asserted in IDLE.
//   Expect err_o=1 next cycle and held, no aw_valid_o, and storec_ready_o still 1.
// - Reset mid-tile: assert rst_n low after 30 rows.
//   Expect all outputs 0 asynchronously; a new STOREC with base=0x8000 then drains 64 rows correctly.
// - Address wrap: base=0xFFFF_FFFF_FFFF_F000.
//   Expect row 16 at 0x0000_0000_0000_0000 and no error flag.

Source files
------------

// File: rtl/sarray_storec_drain_pkg.sv
// Shared widths and FSM state encoding for the STOREC drain path.
package sarray_storec_drain_pkg;

  localparam int ADDR_WIDTH         = 64;
  localparam int SARRAY_STORE_WIDTH = 256;
  localparam int TMMA_CNT_WIDTH     = 6;

  // state  | meaning
  // IDLE   | waiting for a STOREC request; storec_ready_o high
  // DRAIN  | pulling rows from sarray, staging them, writing them out
  // DONE   | single-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sarray_storec_drain_sync_fifo.sv
// Small synchronous staging FIFO with occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage write; contents need no reset because consumers gate on empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sarray_storec_drain.sv
// Drains the accumulated C tile from the systolic array bottom edge into the
// write channel. Rows are pulled one per pulse under a credit scheme so the
// staging FIFO can never overflow, whatever the sarray latency.
module sarray_storec_drain #(
  parameter int ADDR_WIDTH  = sarray_storec_drain_pkg::ADDR_WIDTH,
  parameter int STORE_WIDTH = sarray_storec_drain_pkg::SARRAY_STORE_WIDTH,
  parameter int CNT_WIDTH   = sarray_storec_drain_pkg::TMMA_CNT_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROW_SHIFT   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   storec_valid_i,
  output logic                   storec_ready_o,
  input  logic [ADDR_WIDTH-1:0]  storec_addr_i,
  output logic                   post_storec_valid_o,
  input  logic                   bot_valid_i,
  input  logic [CNT_WIDTH-1:0]   bot_cnt_i,
  input  logic [STORE_WIDTH-1:0] bot_data_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [ADDR_WIDTH-1:0]  aw_addr_o,
  output logic [STORE_WIDTH-1:0] aw_data_o,
  output logic                   storec_done_o,
  output logic                   err_o
);

  import sarray_storec_drain_pkg::*;

  localparam int ROWS  = 1 << CNT_WIDTH;
  localparam int CTR_W = CNT_WIDTH + 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = CNT_WIDTH + STORE_WIDTH;

  state_e                 state_q;
  state_e                 state_d;
  logic                   armed_q;
  logic [ADDR_WIDTH-1:0]  base_r;
  logic [CTR_W-1:0]       req_cnt;
  logic [CTR_W-1:0]       wr_cnt;
  logic [FCW-1:0]         outstanding;
  logic                   err_q;

  logic [FCW-1:0]         fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FW-1:0]          fifo_head;

  logic                   start;
  logic                   row_accept;
  logic                   row_unsol;
  logic                   overflow;
  logic                   aw_hs;
  logic                   last_hs;
  logic [FCW:0]           inflight;
  logic [CNT_WIDTH-1:0]   head_cnt;
  logic [STORE_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0]  row_offset;

  assign start      = storec_valid_i && storec_ready_o;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign last_hs    = aw_hs && (wr_cnt == CTR_W'(ROWS - 1));
  // Rows already staged plus rows requested but not yet seen; one extra bit so the sum cannot wrap.
  assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign row_accept = bot_valid_i && (outstanding != '0);
  assign row_unsol  = bot_valid_i && (outstanding == '0);
  assign overflow   = row_accept && fifo_full && !aw_hs;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request acceptance, row pull pulse, completion pulse.
  always_comb begin
    storec_ready_o      = 1'b0;
    post_storec_valid_o = 1'b0;
    storec_done_o       = 1'b0;
    case (state_q)
      IDLE:  storec_ready_o = armed_q;
      DRAIN: post_storec_valid_o = (req_cnt < CTR_W'(ROWS)) &&
                                   (inflight < (FCW + 1)'(FIFO_DEPTH));
      DONE:  storec_done_o = 1'b1;
      default: ;
    endcase
  end

  // Holds ready low while reset is applied so every output reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Tile base, row request/write counters and credit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r      <= '0;
      req_cnt     <= '0;
      wr_cnt      <= '0;
      outstanding <= '0;
    end else begin
      if (start) begin
        base_r  <= storec_addr_i;
        req_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (post_storec_valid_o) begin
          req_cnt <= req_cnt + CTR_W'(1);
        end
        if (aw_hs) begin
          wr_cnt <= wr_cnt + CTR_W'(1);
        end
      end
      case ({post_storec_valid_o, row_accept})
        2'b10:   outstanding <= outstanding + FCW'(1);
        2'b01:   outstanding <= outstanding - FCW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky error: a row nobody asked for, or a push that found no room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (row_unsol || overflow) begin
      err_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (row_accept),
    .push_data ({bot_cnt_i, bot_data_i}),
    .pop       (aw_hs),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_cnt   = fifo_head[FW-1 -: CNT_WIDTH];
  assign head_data  = fifo_head[STORE_WIDTH-1:0];
  // Address arithmetic wraps at ADDR_WIDTH; no overflow is reported.
  assign row_offset = ADDR_WIDTH'(head_cnt) << ROW_SHIFT;

  // Payload is forced to 0 when nothing is staged so stale entries never leak out.
  assign aw_valid_o = !fifo_empty;
  assign aw_addr_o  = fifo_empty ? '0 : (base_r + row_offset);
  assign aw_data_o  = fifo_empty ? '0 : head_data;
  assign err_o      = err_q;

endmodule

// File: tb/tb_sarray_storec_drain.sv
// Scoreboard bench for sarray_storec_drain: a sarray model answers each pull
// pulse after a set latency and queues the expected write; a monitor pops and
// compares on every aw handshake.
module tb_sarray_storec_drain;

  localparam int AW    = 64;
  localparam int SW    = 256;
  localparam int CW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          storec_valid;
  logic          storec_ready;
  logic [AW-1:0] storec_addr;
  logic          post_storec_valid;
  logic          bot_valid = 1'b0;
  logic [CW-1:0] bot_cnt = '0;
  logic [SW-1:0] bot_data = '0;
  logic          aw_valid;
  logic          aw_ready = 1'b0;
  logic [AW-1:0] aw_addr;
  logic [SW-1:0] aw_data;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  sarray_storec_drain dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .storec_valid_i      (storec_valid),
    .storec_ready_o      (storec_ready),
    .storec_addr_i       (storec_addr),
    .post_storec_valid_o (post_storec_valid),
    .bot_valid_i         (bot_valid),
    .bot_cnt_i           (bot_cnt),
    .bot_data_i          (bot_data),
    .aw_valid_o          (aw_valid),
    .aw_ready_i          (aw_ready),
    .aw_addr_o           (aw_addr),
    .aw_data_o           (aw_data),
    .storec_done_o       (done),
    .err_o               (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   pend[$];

  int tests = 0;
  int fails = 0;

  // tile configuration, written by the main sequence only
  logic [AW-1:0] cur_base = '0;
  logic [7:0]    tag = '0;
  int            lat = 1;
  int            rdy_mode = 0;
  int            tile_seq = 0;
  int            inj_seq = 0;

  // sarray model state
  int cyc = 0;
  int model_seq = 0;
  int inj_ack = 0;
  int row_next = 0;
  int pulses = 0;
  int stall_left = 0;
  bit stall_used = 0;
  int max_inflight = 0;

  // monitor state
  int            mon_seq = 0;
  int            hs_cnt = 0;
  int            last_hs_cyc = 0;
  bit            done_seen = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [SW-1:0] prev_data = '0;
  logic [AW-1:0] addr_log [64];

  function automatic logic [SW-1:0] row_data(input logic [7:0] t, input int row);
    logic [31:0] w;
    w = {t, 8'hA5, 10'h0, row[5:0]};
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sarray model: answers each pulse after lat cycles and drives aw_ready.
  always @(negedge clk) begin : model_p
    exp_t e;
    if (!rst_n) begin
      pend.delete();
      sb.delete();
      bot_valid = 1'b0;
      aw_ready  = 1'b0;
    end else begin
      cyc++;
      if (tile_seq != model_seq) begin
        model_seq    = tile_seq;
        row_next     = 0;
        pulses       = 0;
        stall_used   = 0;
        stall_left   = 0;
        max_inflight = 0;
      end
      if (pend.size() > 0 && pend[0] <= cyc) begin
        void'(pend.pop_front());
        e.addr    = cur_base + (64'(row_next) << 8);
        e.data    = row_data(tag, row_next);
        bot_valid = 1'b1;
        bot_cnt   = row_next[5:0];
        bot_data  = e.data;
        sb.push_back(e);
        row_next++;
      end else if (inj_seq != inj_ack) begin
        inj_ack   = inj_seq;
        bot_valid = 1'b1;
        bot_cnt   = 6'd5;
        bot_data  = {SW{1'b1}};
      end else begin
        bot_valid = 1'b0;
      end
      case (rdy_mode)
        1: begin
          if (!stall_used && row_next >= 12) begin
            stall_used = 1;
            stall_left = 20;
          end
          if (stall_left > 0) begin
            aw_ready = 1'b0;
            stall_left--;
          end else begin
            aw_ready = 1'b1;
          end
        end
        2:       aw_ready = 1'($urandom_range(0, 1));
        default: aw_ready = 1'b1;
      endcase
      if (post_storec_valid) begin
        pulses++;
        pend.push_back(cyc + lat);
      end
      if (pend.size() + sb.size() > max_inflight) begin
        max_inflight = pend.size() + sb.size();
      end
    end
  end

  // Monitor: compares every aw handshake against the scoreboard head.
  always begin : monitor_p
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (tile_seq != mon_seq) begin
        mon_seq   = tile_seq;
        hs_cnt    = 0;
        done_seen = 0;
      end
      if (prev_stall) begin
        check("stall_valid", SW'(aw_valid), SW'(1));
        check("stall_addr", SW'(aw_addr), SW'(prev_addr));
        check("stall_data", aw_data, prev_data);
      end
      if (aw_valid && aw_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL aw_unexpected: got write at %0h expected none", aw_addr);
        end else begin
          e = sb.pop_front();
          check("aw_addr", SW'(aw_addr), SW'(e.addr));
          check("aw_data", aw_data, e.data);
        end
        if (hs_cnt < 64) addr_log[hs_cnt] = aw_addr;
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      prev_stall = aw_valid && !aw_ready;
      prev_addr  = aw_addr;
      prev_data  = aw_data;
      if (done) begin
        done_seen = 1;
        check("done_timing", SW'(cyc), SW'(last_hs_cyc + 1));
        check("done_rows", SW'(hs_cnt), SW'(64));
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check({name, "_ready"}, SW'(storec_ready), '0);
    check({name, "_pulse"}, SW'(post_storec_valid), '0);
    check({name, "_aw_valid"}, SW'(aw_valid), '0);
    check({name, "_aw_addr"}, SW'(aw_addr), '0);
    check({name, "_aw_data"}, aw_data, '0);
    check({name, "_done"}, SW'(done), '0);
    check({name, "_err"}, SW'(err), '0);
  endtask

  task automatic run_tile(input logic [AW-1:0] base, input int l, input int mode,
                          input logic [7:0] t, input bit wait_done);
    int n;
    @(negedge clk);
    #2;
    cur_base = base;
    lat      = l;
    rdy_mode = mode;
    tag      = t;
    tile_seq++;
    check("storec_ready_idle", SW'(storec_ready), SW'(1));
    storec_valid = 1'b1;
    storec_addr  = base;
    @(negedge clk);
    #2;
    storec_valid = 1'b0;
    storec_addr  = '0;
    check("storec_ready_drain", SW'(storec_ready), '0);
    if (wait_done) begin
      n = 0;
      while (!done_seen && n < 3000) begin
        @(negedge clk);
        #2;
        n++;
      end
      if (!done_seen) begin
        tests++;
        fails++;
        $display("FAIL done_timeout: got %0d writes expected 64 and a done pulse", hs_cnt);
      end
      check("tile_pulses", SW'(pulses), SW'(64));
      check("tile_writes", SW'(hs_cnt), SW'(64));
      check("tile_sb_empty", SW'(sb.size()), '0);
      check("tile_err", SW'(err), '0);
      check("tile_inflight_le_depth", SW'(max_inflight <= DEPTH), SW'(1));
    end
  endtask

  initial begin : main_p
    int n;
    rst_n        = 1'b0;
    storec_valid = 1'b0;
    storec_addr  = '0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("ready_after_reset", SW'(storec_ready), SW'(1));

    // basic drain
    run_tile(64'h1000, 1, 0, 8'h11, 1);
    check("basic_row0_addr", SW'(addr_log[0]), SW'(64'h1000));
    check("basic_row1_addr", SW'(addr_log[1]), SW'(64'h1100));
    check("basic_row63_addr", SW'(addr_log[63]), SW'(64'h4F00));

    // aw backpressure for 20 cycles mid-tile
    run_tile(64'h2_0000, 1, 1, 8'h22, 1);
    check("bp_row63_addr", SW'(addr_log[63]), SW'(64'h2_3F00));

    // sarray latency 7 with random aw_ready
    run_tile(64'h3_0000, 7, 2, 8'h33, 1);
    check("lat7_row0_addr", SW'(addr_log[0]), SW'(64'h3_0000));

    // address wrap
    run_tile(64'hFFFF_FFFF_FFFF_F000, 1, 0, 8'h44, 1);
    check("wrap_row15_addr", SW'(addr_log[15]), SW'(64'hFFFF_FFFF_FFFF_FF00));
    check("wrap_row16_addr", SW'(addr_log[16]), SW'(64'h0));
    check("wrap_row63_addr", SW'(addr_log[63]), SW'(64'h2F00));

    // reset after 30 rows written, then a fresh tile
    run_tile(64'h5000, 3, 0, 8'h55, 0);
    n = 0;
    while (hs_cnt < 30 && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("midtile_reached_30", SW'(hs_cnt >= 30), SW'(1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midtile_rst");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_tile(64'h8000, 2, 0, 8'h66, 1);
    check("post_rst_row0_addr", SW'(addr_log[0]), SW'(64'h8000));
    check("post_rst_row63_addr", SW'(addr_log[63]), SW'(64'hBF00));

    // unsolicited row while idle
    @(negedge clk);
    #2;
    inj_seq++;
    @(negedge clk);
    #2;
    check("unsol_err_not_yet", SW'(err), '0);
    @(negedge clk);
    #2;
    check("unsol_err_set", SW'(err), SW'(1));
    check("unsol_no_aw", SW'(aw_valid), '0);
    check("unsol_ready", SW'(storec_ready), SW'(1));
    repeat (5) @(negedge clk);
    #2;
    check("unsol_err_sticky", SW'(err), SW'(1));
    check("unsol_no_pulse", SW'(post_storec_valid), '0);
    rst_n = 1'b0;
    #1;
    check("unsol_err_cleared", SW'(err), '0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
